// File: rtl/acc_pkg.sv
// Shared types and defaults for the product accumulator.
// The saturation option (PRODUCT_ACCUMULATOR_SATURATE_EN) is selected in the top module.
package acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_PROD_W = 6;
  localparam int DEF_ACC_W  = 12;
  localparam int DEF_COUNT  = 4;

  // Counter must hold 0..COUNT inclusive.
  function automatic int cnt_width(input int count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/acc_adder.sv
// Combinational W-bit adder with carry out; optionally clamps the sum to all-ones on carry.
// Purely combinational, no backpressure.
module acc_adder
  import acc_pkg::*;
#(
  parameter int W        = DEF_ACC_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] raw;

  always_comb begin
    raw   = {1'b0, a} + {1'b0, b};
    carry = raw[W];
    sum   = (SATURATE && raw[W]) ? {W{1'b1}} : raw[W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT multiplier products per frame and offers the total on a valid/ready port.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp the accumulator instead of wrapping.
module product_accumulator
  import acc_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int COUNT  = DEF_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = cnt_width(COUNT);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;
  logic               last_prod;

  acc_adder #(
    .W        (ACC_W),
    .SATURATE (SAT)
  ) u_adder (
    .a     (acc_q),
    .b     (ACC_W'(in_prod)),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign last_prod = (cnt_q == CNT_W'(COUNT - 1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    if (clear) begin
      // Abort wins over both handshakes; a product offered now is dropped.
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      out_ovf_d   = 1'b0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else if (state_q == ACCUM) begin
      if (in_valid) begin
        acc_d     = add_sum;
        cnt_d     = cnt_q + 1'b1;
        out_ovf_d = out_ovf_q | add_carry;
        if (last_prod) begin
          state_d     = HOLD;
          out_sum_d   = add_sum;
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
        end
      end
    end else begin
      if (out_ready) begin
        state_d     = ACCUM;
        acc_d       = '0;
        cnt_d       = '0;
        out_ovf_d   = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: three accumulator configurations share one stimulus stream.
// Expected sums come from plain frame totals reduced modulo 2^ACC_W or clamped.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_prod = '0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_m, out_valid_m, out_ovf_m;
  logic [11:0] out_sum_m;
  logic        in_ready_o, out_valid_o, out_ovf_o;
  logic [6:0]  out_sum_o;
  logic        in_ready_1, out_valid_1, out_ovf_1;
  logic [11:0] out_sum_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(6), .ACC_W(12), .COUNT(4)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_prod(in_prod), .clear(clear), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_sum(out_sum_m), .out_ovf(out_ovf_m));

  product_accumulator #(.PROD_W(6), .ACC_W(7), .COUNT(4)) u_ovf (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o),
    .in_prod(in_prod), .clear(clear), .out_valid(out_valid_o),
    .out_ready(out_ready), .out_sum(out_sum_o), .out_ovf(out_ovf_o));

  product_accumulator #(.PROD_W(6), .ACC_W(12), .COUNT(1)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_prod(in_prod), .clear(clear), .out_valid(out_valid_1),
    .out_ready(out_ready), .out_sum(out_sum_1), .out_ovf(out_ovf_1));

  // Reference: frame result from the plain integer total of its products.
  function automatic int exp_sum(input int total, input int w);
    int maxv;
    maxv = (1 << w) - 1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    return (total > maxv) ? maxv : total;
`else
    return total % (1 << w);
`endif
  endfunction

  function automatic logic exp_ovf(input int total, input int w);
    return total > ((1 << w) - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int p);
    in_valid = 1'b1;
    in_prod  = 6'(p);
    step();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; in_prod = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_m); end
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_m); end
    checks++; if (out_sum_m !== 12'd0) begin errors++; $display("FAIL reset_out_sum got %0d want 0", out_sum_m); end
    checks++; if (out_ovf_m !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf_m); end
  endtask

  task automatic test_frame_sum();
    do_reset();
    out_ready = 1'b1;
    feed(24); feed(36); feed(49);
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL frame_early_valid got %b want 0", out_valid_m); end
    feed(6);
    in_valid = 1'b0;
    checks++; if (out_valid_m !== 1'b1) begin errors++; $display("FAIL frame_valid got %b want 1", out_valid_m); end
    checks++; if (out_sum_m !== 12'd115) begin errors++; $display("FAIL frame_sum got %0d want 115", out_sum_m); end
    checks++; if (out_ovf_m !== 1'b0) begin errors++; $display("FAIL frame_ovf got %b want 0", out_ovf_m); end
    checks++; if (in_ready_m !== 1'b0) begin errors++; $display("FAIL frame_hold_ready got %b want 0", in_ready_m); end
    step();
    checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL frame_ready_after got %b want 1", in_ready_m); end
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL frame_valid_after got %b want 0", out_valid_m); end
    checks++; if (out_sum_m !== 12'd115) begin errors++; $display("FAIL frame_sum_kept got %0d want 115", out_sum_m); end
  endtask

  task automatic test_backpressure();
    int p[4];
    int total;
    do_reset();
    out_ready = 1'b0;
    feed(24); feed(36); feed(49); feed(6);
    for (int i = 0; i < 5; i++) begin
      feed(49);
      checks++; if (out_sum_m !== 12'd115 || out_valid_m !== 1'b1 || in_ready_m !== 1'b0)
        begin errors++; $display("FAIL bp_hold cycle %0d got sum=%0d vld=%b rdy=%b want 115/1/0", i, out_sum_m, out_valid_m, in_ready_m); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    total = 0;
    for (int i = 0; i < 4; i++) begin
      p[i] = int'($urandom_range(0, 7)) * int'($urandom_range(0, 7));
      total += p[i];
      feed(p[i]);
    end
    in_valid = 1'b0;
    checks++; if (out_valid_m !== 1'b1 || out_sum_m !== 12'(exp_sum(total, 12)))
      begin errors++; $display("FAIL bp_next_frame got vld=%b sum=%0d want 1/%0d", out_valid_m, out_sum_m, exp_sum(total, 12)); end
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b1;
    feed(49); feed(49);
    checks++; if (out_ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", out_ovf_o); end
    feed(49);
    checks++; if (out_ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky_mid got %b want 1", out_ovf_o); end
    feed(49);
    in_valid = 1'b0;
    checks++; if (out_sum_o !== 7'(exp_sum(196, 7))) begin errors++; $display("FAIL ovf_sum got %0d want %0d", out_sum_o, exp_sum(196, 7)); end
    checks++; if (out_ovf_o !== exp_ovf(196, 7)) begin errors++; $display("FAIL ovf_flag got %b want 1", out_ovf_o); end
    checks++; if (out_sum_m !== 12'd196 || out_ovf_m !== 1'b0) begin errors++; $display("FAIL ovf_wide got %0d/%b want 196/0", out_sum_m, out_ovf_m); end
    step();
    checks++; if (out_ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", out_ovf_o); end
  endtask

  task automatic test_clear();
    do_reset();
    out_ready = 1'b1;
    feed(24); feed(36);
    clear = 1'b1;
    feed(49);
    clear = 1'b0;
    checks++; if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || out_ovf_m !== 1'b0)
      begin errors++; $display("FAIL clear_state got rdy=%b vld=%b ovf=%b want 1/0/0", in_ready_m, out_valid_m, out_ovf_m); end
    feed(6); feed(6); feed(6);
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL clear_count got vld=%b want 0", out_valid_m); end
    feed(6);
    in_valid = 1'b0;
    checks++; if (out_valid_m !== 1'b1 || out_sum_m !== 12'd24) begin errors++; $display("FAIL clear_sum got vld=%b sum=%0d want 1/24", out_valid_m, out_sum_m); end
    // Clear while holding a result also abandons it.
    out_ready = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin errors++; $display("FAIL clear_hold got vld=%b rdy=%b want 0/1", out_valid_m, in_ready_m); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    feed(24); feed(24); feed(24); feed(24);
    in_valid = 1'b0;
    step();
    feed(49); feed(49);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++; if (out_sum_m !== 12'd0 || out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || out_ovf_m !== 1'b0)
      begin errors++; $display("FAIL rst_async got sum=%0d vld=%b rdy=%b ovf=%b want 0/0/1/0", out_sum_m, out_valid_m, in_ready_m, out_ovf_m); end
    rst_n = 1'b1;
    step();
    feed(1); feed(1); feed(1); feed(1);
    in_valid = 1'b0;
    checks++; if (out_valid_m !== 1'b1 || out_sum_m !== 12'd4) begin errors++; $display("FAIL rst_next_frame got vld=%b sum=%0d want 1/4", out_valid_m, out_sum_m); end
    step();
  endtask

  task automatic test_count_one();
    int p;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p = (i < 2) ? 49 : int'($urandom_range(0, 7)) * int'($urandom_range(0, 7));
      feed(p);
      checks++; if (out_valid_1 !== 1'b1 || out_sum_1 !== 12'(p) || in_ready_1 !== 1'b0)
        begin errors++; $display("FAIL count1_frame %0d got vld=%b sum=%0d rdy=%b want 1/%0d/0", i, out_valid_1, out_sum_1, in_ready_1, p); end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid_1 !== 1'b0 || in_ready_1 !== 1'b1)
        begin errors++; $display("FAIL count1_release %0d got vld=%b rdy=%b want 0/1", i, out_valid_1, in_ready_1); end
    end
  endtask

  task automatic test_random();
    int exp_q[$];
    int total, n, frames, p;
    do_reset();
    total = 0; n = 0; frames = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      p         = int'($urandom_range(0, 7)) * int'($urandom_range(0, 7));
      in_prod   = 6'(p);
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid_m) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_spurious_valid cycle %0d sum=%0d", cyc, out_sum_m);
        end else begin
          checks++;
          if (out_sum_m !== 12'(exp_sum(exp_q[0], 12)) || out_ovf_m !== exp_ovf(exp_q[0], 12) ||
              out_sum_o !== 7'(exp_sum(exp_q[0], 7)) || out_ovf_o !== exp_ovf(exp_q[0], 7)) begin
            errors++;
            $display("FAIL rand_frame cycle %0d got %0d/%b %0d/%b want total %0d", cyc, out_sum_m, out_ovf_m, out_sum_o, out_ovf_o, exp_q[0]);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            frames++;
          end
        end
      end
      if (in_valid && in_ready_m) begin
        total += p; n++;
        if (n == 4) begin
          exp_q.push_back(total);
          total = 0; n = 0;
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (frames < 20) begin errors++; $display("FAIL rand_frames got %0d want >=20", frames); end
  endtask

  initial begin
    test_reset();
    test_frame_sum();
    test_backpressure();
    test_overflow();
    test_clear();
    test_reset_mid();
    test_count_one();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
